// File: rtl/checkpoint_seq_monitor.sv
// ----------------------------------------------------------------------------
// checkpoint_seq_monitor
//
// Watches a CHECK_W-bit status bus and checks it against a programmable
// ordered list of up to DEPTH checkpoint codes. Reports pass, fail or timeout,
// with the failure cause and how many checkpoints were matched.
//
// The bus is asynchronous to wb_clk_i. It goes through a 2-flop synchroniser
// and then a stability filter. A value is accepted only after the synchronised
// sample has stayed the same for STABLE_CYC consecutive cycles, so skew
// between bits during a change is never seen as a code.
//
// Ports
//   wb_clk_i     clock
//   wb_rst_i     asynchronous reset, active high
//   check_bits   monitored status bus (asynchronous)
//   exp_we       write exp_data into entry exp_idx (ignored while busy)
//   exp_idx      table write index
//   exp_data     expected checkpoint code
//   seq_len      number of entries to check (0..DEPTH), latched at start
//   timeout_lim  cycle limit, latched at start; 0 disables the timeout
//   start        single-cycle arm request
//   abort        return to idle and clear the result flags
//   busy         a run is in progress
//   pass         whole sequence matched (sticky until start/abort)
//   fail         run failed (sticky until start/abort)
//   fail_code    0 none, 1 timeout, 2 order violation
//   stage        entries matched so far
//   elapsed      cycles spent in the current run, saturating
//   dbg_state    current controller state (IDLE=0, RUN=1, PASS=2, FAIL=3)
//
// Handshake: start is a one-cycle request. It is taken in any state where
// busy is low; while busy is high it is dropped without effect. Completion is
// signalled by busy falling with exactly one of pass/fail set.
// ----------------------------------------------------------------------------
module checkpoint_seq_monitor #(
   parameter int  CHECK_W    = 16,
   parameter int  DEPTH      = 8,
   parameter int  TIMEOUT_W  = 24,
   parameter int  STABLE_CYC = 2,
   parameter int  STRICT     = 0,
   localparam int IW         = $clog2(DEPTH)
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [CHECK_W-1:0]   check_bits,
   input  logic                 exp_we,
   input  logic [IW-1:0]        exp_idx,
   input  logic [CHECK_W-1:0]   exp_data,
   input  logic [IW:0]          seq_len,
   input  logic [TIMEOUT_W-1:0] timeout_lim,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 pass,
   output logic                 fail,
   output logic [1:0]           fail_code,
   output logic [IW:0]          stage,
   output logic [TIMEOUT_W-1:0] elapsed,
   output logic [1:0]           dbg_state
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   state_t               state;
   logic [CHECK_W-1:0]   sync1;
   logic [CHECK_W-1:0]   sync2;
   logic [CHECK_W-1:0]   filt_val;
   logic [CW-1:0]        run_cnt;
   logic [CHECK_W-1:0]   exp_tab [DEPTH];
   logic [IW:0]          len_q;
   logic [TIMEOUT_W-1:0] lim_q;
   logic                 consumed;

   logic                 same_run;
   logic [CW:0]          run_len;
   logic                 stable;
   logic                 consumed_eff;
   logic                 cand;
   logic                 hit;
   logic                 final_hit;
   logic                 later_hit;
   logic                 order_hit;
   logic                 timeout_hit;
   logic [IW-1:0]        stage_idx;
   logic [IW:0]          stage_inc;
   logic [TIMEOUT_W-1:0] elapsed_nxt;

   assign busy      = (state == S_RUN);
   assign dbg_state = state;

   // Synchroniser and stability filter. filt_val/run_cnt remember the value
   // the synchronised sample has been holding and for how many cycles.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1    <= '0;
         sync2    <= '0;
         filt_val <= '0;
         run_cnt  <= '0;
      end else begin
         sync1 <= check_bits;
         sync2 <= sync1;
         if (sync2 != filt_val) begin
            filt_val <= sync2;
            run_cnt  <= CW'(1);
         end else if (run_cnt != CW'(STABLE_CYC)) begin
            run_cnt <= run_cnt + CW'(1);
         end
      end
   end

   // Expected-code table; contents are undefined after reset.
   always_ff @(posedge wb_clk_i) begin
      if (exp_we && (state != S_RUN)) begin
         exp_tab[exp_idx] <= exp_data;
      end
   end

   always_comb begin
      same_run     = (sync2 == filt_val);
      // run_len counts the current sample too, so it is at least 1.
      run_len      = same_run ? ({1'b0, run_cnt} + (CW+1)'(1)) : (CW+1)'(1);
      stable       = (run_len >= (CW+1)'(STABLE_CYC));
      // A consumed episode ends as soon as the synchronised value changes.
      consumed_eff = consumed && same_run;
      cand         = stable && !consumed_eff && (state == S_RUN);
      stage_idx    = stage[IW-1:0];
      stage_inc    = stage + (IW+1)'(1);
      hit          = cand && (sync2 == exp_tab[stage_idx]);
      final_hit    = hit && (stage_inc == len_q);
      later_hit    = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         if (((IW+1)'(j) > stage) && ((IW+1)'(j) < len_q) && (exp_tab[j] == sync2)) begin
            later_hit = 1'b1;
         end
      end
      order_hit    = (STRICT != 0) && cand && !hit && later_hit;
      timeout_hit  = (lim_q != '0) &&
                     (({1'b0, elapsed} + (TIMEOUT_W+1)'(1)) == {1'b0, lim_q});
      elapsed_nxt  = (elapsed == '1) ? elapsed : (elapsed + TIMEOUT_W'(1));
   end

   // Controller. elapsed advances on every RUN cycle that stays in RUN, so a
   // timeout leaves it at timeout_lim-1.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= S_IDLE;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_code <= 2'd0;
         stage     <= '0;
         elapsed   <= '0;
         len_q     <= '0;
         lim_q     <= '0;
         consumed  <= 1'b0;
      end else if (abort) begin
         state     <= S_IDLE;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_code <= 2'd0;
         stage     <= '0;
         consumed  <= 1'b0;
      end else begin
         consumed <= consumed_eff;
         case (state)
            S_RUN: begin
               if (hit) begin
                  stage    <= stage_inc;
                  consumed <= 1'b1;
               end
               if (final_hit) begin
                  pass  <= 1'b1;
                  state <= S_PASS;
               end else if (order_hit) begin
                  fail      <= 1'b1;
                  fail_code <= 2'd2;
                  state     <= S_FAIL;
               end else if (timeout_hit) begin
                  fail      <= 1'b1;
                  fail_code <= 2'd1;
                  state     <= S_FAIL;
               end else begin
                  elapsed <= elapsed_nxt;
               end
            end
            default: begin
               if (start) begin
                  len_q     <= seq_len;
                  lim_q     <= timeout_lim;
                  stage     <= '0;
                  elapsed   <= '0;
                  fail      <= 1'b0;
                  fail_code <= 2'd0;
                  consumed  <= 1'b0;
                  if (seq_len == '0) begin
                     pass  <= 1'b1;
                     state <= S_PASS;
                  end else begin
                     pass  <= 1'b0;
                     state <= S_RUN;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
`timescale 1ns/1ps
module tb_checkpoint_seq_monitor;

   localparam int CHECK_W    = 16;
   localparam int DEPTH      = 8;
   localparam int TIMEOUT_W  = 24;
   localparam int STABLE_CYC = 2;
   localparam int IW         = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [CHECK_W-1:0]   check_bits;
   logic                 exp_we;
   logic [IW-1:0]        exp_idx;
   logic [CHECK_W-1:0]   exp_data;
   logic [IW:0]          seq_len;
   logic [TIMEOUT_W-1:0] timeout_lim;
   logic                 start;
   logic                 abort;

   // index 0: STRICT=0 instance, index 1: STRICT=1 instance
   logic                 busy_o      [2];
   logic                 pass_o      [2];
   logic                 fail_o      [2];
   logic [1:0]           fail_code_o [2];
   logic [IW:0]          stage_o     [2];
   logic [TIMEOUT_W-1:0] elapsed_o   [2];
   logic [1:0]           dbg_o       [2];

   checkpoint_seq_monitor #(.STRICT(0)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .check_bits(check_bits),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
      .seq_len(seq_len), .timeout_lim(timeout_lim), .start(start), .abort(abort),
      .busy(busy_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .fail_code(fail_code_o[0]),
      .stage(stage_o[0]), .elapsed(elapsed_o[0]), .dbg_state(dbg_o[0])
   );

   checkpoint_seq_monitor #(.STRICT(1)) u_dut_strict (
      .wb_clk_i(clk), .wb_rst_i(rst), .check_bits(check_bits),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
      .seq_len(seq_len), .timeout_lim(timeout_lim), .start(start), .abort(abort),
      .busy(busy_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .fail_code(fail_code_o[1]),
      .stage(stage_o[1]), .elapsed(elapsed_o[1]), .dbg_state(dbg_o[1])
   );

   // ---------------- scoreboard / counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist holds the bus value presented before each clock edge (0 while in
   // reset). The synchronised sample seen before edge n is hist[n-2]; a run of
   // equal samples is an episode identified by the index where it began.
   logic [CHECK_W-1:0] hist [$];
   localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
   int                 m_state   [2];
   int                 m_stage   [2];
   int                 m_elapsed [2];
   int                 m_len     [2];
   int                 m_lim     [2];
   int                 m_code    [2];
   int                 m_used    [2];
   bit                 m_pass    [2];
   bit                 m_fail    [2];
   logic [CHECK_W-1:0] m_tab     [2][DEPTH];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_state[i] = M_IDLE; m_stage[i] = 0; m_elapsed[i] = 0;
         m_len[i] = 0; m_lim[i] = 0; m_code[i] = 0; m_used[i] = -1;
         m_pass[i] = 0; m_fail[i] = 0;
      end
   endtask

   task automatic model_step();
      int n, p, ep;
      logic [CHECK_W-1:0] sv;
      bit st, cand, hit, later, wr;
      if (rst) begin
         model_reset();
         hist.push_back('0);
      end else begin
         n  = hist.size();
         p  = n - 2;
         sv = hist[p];
         st = 1;
         for (int k = 1; k < STABLE_CYC; k++) if (hist[p-k] != sv) st = 0;
         ep = p;
         while (ep > 0 && hist[ep-1] == sv) ep--;
         for (int i = 0; i < 2; i++) begin
            wr = exp_we && (m_state[i] != M_RUN);
            if (abort) begin
               m_state[i] = M_IDLE; m_pass[i] = 0; m_fail[i] = 0;
               m_code[i] = 0; m_stage[i] = 0; m_used[i] = -1;
            end else if (m_state[i] == M_RUN) begin
               cand  = st && (ep != m_used[i]);
               hit   = cand && (sv == m_tab[i][m_stage[i]]);
               later = 0;
               for (int j = m_stage[i] + 1; j < m_len[i]; j++) if (m_tab[i][j] == sv) later = 1;
               if (hit) begin
                  m_stage[i]++;
                  m_used[i] = ep;
               end
               if (hit && m_stage[i] == m_len[i]) begin
                  m_pass[i] = 1; m_state[i] = M_PASS;
               end else if (i == 1 && cand && !hit && later) begin
                  m_fail[i] = 1; m_code[i] = 2; m_state[i] = M_FAIL;
               end else if (m_lim[i] != 0 && m_elapsed[i] + 1 == m_lim[i]) begin
                  m_fail[i] = 1; m_code[i] = 1; m_state[i] = M_FAIL;
               end else if (m_elapsed[i] < 24'hFFFFFF) begin
                  m_elapsed[i]++;
               end
            end else if (start) begin
               m_len[i] = int'(seq_len); m_lim[i] = int'(timeout_lim);
               m_stage[i] = 0; m_elapsed[i] = 0; m_fail[i] = 0; m_code[i] = 0;
               m_used[i] = -1;
               if (seq_len == 0) begin
                  m_pass[i] = 1; m_state[i] = M_PASS;
               end else begin
                  m_pass[i] = 0; m_state[i] = M_RUN;
               end
            end
            if (wr) m_tab[i][exp_idx] = exp_data;
         end
         hist.push_back(check_bits);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("busy%0d", i),    32'(busy_o[i]),      32'(m_state[i] == M_RUN));
         check_eq($sformatf("pass%0d", i),    32'(pass_o[i]),      32'(m_pass[i]));
         check_eq($sformatf("fail%0d", i),    32'(fail_o[i]),      32'(m_fail[i]));
         check_eq($sformatf("code%0d", i),    32'(fail_code_o[i]), 32'(m_code[i]));
         check_eq($sformatf("stage%0d", i),   32'(stage_o[i]),     32'(m_stage[i]));
         check_eq($sformatf("elapsed%0d", i), 32'(elapsed_o[i]),   32'(m_elapsed[i]));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic hold_code(input logic [CHECK_W-1:0] c, input int n);
      check_bits = c;
      repeat (n) tick();
   endtask

   task automatic write_tab(input int idx, input logic [CHECK_W-1:0] d);
      exp_we = 1'b1; exp_idx = IW'(idx); exp_data = d;
      tick();
      exp_we = 1'b0;
   endtask

   task automatic pulse_start(input int len, input int lim);
      seq_len = (IW+1)'(len); timeout_lim = TIMEOUT_W'(lim); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic async_reset_now();
      rst = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("rst_busy%0d", i),    32'(busy_o[i]),      32'd0);
         check_eq($sformatf("rst_pass%0d", i),    32'(pass_o[i]),      32'd0);
         check_eq($sformatf("rst_fail%0d", i),    32'(fail_o[i]),      32'd0);
         check_eq($sformatf("rst_code%0d", i),    32'(fail_code_o[i]), 32'd0);
         check_eq($sformatf("rst_stage%0d", i),   32'(stage_o[i]),     32'd0);
         check_eq($sformatf("rst_elapsed%0d", i), 32'(elapsed_o[i]),   32'd0);
      end
      repeat (3) tick();
      rst = 1'b0;
      hold_code(check_bits, 5);
   endtask

   logic [CHECK_W-1:0] alph [4];

   // ---------------- stimulus ----------------
   initial begin
      alph[0] = 16'hAB40; alph[1] = 16'hAB41; alph[2] = 16'hAB51; alph[3] = 16'hAB52;
      rst = 1'b1; check_bits = '0; exp_we = 1'b0; exp_idx = '0; exp_data = '0;
      seq_len = '0; timeout_lim = '0; start = 1'b0; abort = 1'b0;
      for (int k = 0; k < 8; k++) hist.push_back('0);
      for (int i = 0; i < 2; i++) for (int j = 0; j < DEPTH; j++) m_tab[i][j] = '0;
      model_reset();
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("reset_busy%0d", i),  32'(busy_o[i]),  32'd0);
         check_eq($sformatf("reset_stage%0d", i), 32'(stage_o[i]), 32'd0);
      end
      rst = 1'b0;
      hold_code('0, 5);
      for (int j = 0; j < DEPTH; j++) write_tab(j, 16'hFFFF);

      // 1: in-order sequence, pass on 4th edge after the last code appears
      write_tab(0, 16'hAB40); write_tab(1, 16'hAB41); write_tab(2, 16'hAB51);
      pulse_start(3, 0);
      hold_code(16'hAB40, 10);
      for (int i = 0; i < 2; i++) check_eq($sformatf("t1_stage1_%0d", i), 32'(stage_o[i]), 32'd1);
      hold_code(16'hAB41, 10);
      for (int i = 0; i < 2; i++) check_eq($sformatf("t1_stage2_%0d", i), 32'(stage_o[i]), 32'd2);
      hold_code(16'hAB51, 3);
      for (int i = 0; i < 2; i++) check_eq($sformatf("t1_nopass3_%0d", i), 32'(pass_o[i]), 32'd0);
      hold_code(16'hAB51, 1);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("t1_pass4_%0d", i), 32'(pass_o[i]), 32'd1);
         check_eq($sformatf("t1_stage3_%0d", i), 32'(stage_o[i]), 32'd3);
         check_eq($sformatf("t1_fail_%0d", i), 32'(fail_o[i]), 32'd0);
      end
      hold_code(16'hAB51, 6);

      // 2: timeout after AB40 only
      pulse_abort(); hold_code('0, 4);
      pulse_start(3, 50);
      hold_code(16'hAB40, 60);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("t2_fail_%0d", i), 32'(fail_o[i]), 32'd1);
         check_eq($sformatf("t2_code_%0d", i), 32'(fail_code_o[i]), 32'd1);
         check_eq($sformatf("t2_elapsed_%0d", i), 32'(elapsed_o[i]), 32'd49);
         check_eq($sformatf("t2_stage_%0d", i), 32'(stage_o[i]), 32'd1);
         check_eq($sformatf("t2_busy_%0d", i), 32'(busy_o[i]), 32'd0);
      end

      // 3: out-of-order code
      pulse_abort(); hold_code('0, 4);
      pulse_start(3, 0);
      hold_code(16'hAB40, 10);
      hold_code(16'hAB51, 10);
      check_eq("t3_strict_fail", 32'(fail_o[1]), 32'd1);
      check_eq("t3_strict_code", 32'(fail_code_o[1]), 32'd2);
      check_eq("t3_strict_stage", 32'(stage_o[1]), 32'd1);
      check_eq("t3_loose_busy", 32'(busy_o[0]), 32'd1);
      check_eq("t3_loose_stage", 32'(stage_o[0]), 32'd1);

      // 4: one-cycle glitch, then repeated entry with one long hold
      pulse_abort(); hold_code('0, 4);
      pulse_start(3, 0);
      hold_code(16'hAB40, 10); hold_code(16'hAB41, 1); hold_code(16'hAB40, 10);
      for (int i = 0; i < 2; i++) check_eq($sformatf("t4_glitch_stage_%0d", i), 32'(stage_o[i]), 32'd1);
      pulse_abort(); write_tab(1, 16'hAB40); hold_code('0, 4);
      pulse_start(2, 0);
      hold_code(16'hAB40, 20);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("t4_repeat_stage_%0d", i), 32'(stage_o[i]), 32'd1);
         check_eq($sformatf("t4_repeat_busy_%0d", i), 32'(busy_o[i]), 32'd1);
      end

      // 5: empty sequence, start while busy, write while busy
      pulse_abort(); hold_code('0, 4);
      pulse_start(0, 0);
      for (int i = 0; i < 2; i++) check_eq($sformatf("t5_len0_pass_%0d", i), 32'(pass_o[i]), 32'd1);
      pulse_start(3, 0);
      pulse_start(0, 0);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("t5_restart_busy_%0d", i), 32'(busy_o[i]), 32'd1);
         check_eq($sformatf("t5_restart_pass_%0d", i), 32'(pass_o[i]), 32'd0);
      end
      write_tab(0, 16'h1234);
      pulse_abort();
      pulse_start(1, 0);
      hold_code(16'hAB40, 6);
      for (int i = 0; i < 2; i++) check_eq($sformatf("t5_tab_kept_%0d", i), 32'(pass_o[i]), 32'd1);

      // 6: reset mid-run, abort in PASS, final match on the timeout cycle
      pulse_abort(); write_tab(1, 16'hAB41); hold_code('0, 4);
      pulse_start(3, 0);
      hold_code(16'hAB40, 6); hold_code(16'hAB41, 6);
      for (int i = 0; i < 2; i++) check_eq($sformatf("t6_stage2_%0d", i), 32'(stage_o[i]), 32'd2);
      async_reset_now();
      pulse_start(0, 0);
      pulse_abort();
      for (int i = 0; i < 2; i++) check_eq($sformatf("t6_abort_pass_%0d", i), 32'(pass_o[i]), 32'd0);
      write_tab(0, 16'hAB51);
      hold_code(16'hAB51, 6);
      pulse_start(1, 1);
      tick();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("t6_tie_pass_%0d", i), 32'(pass_o[i]), 32'd1);
         check_eq($sformatf("t6_tie_fail_%0d", i), 32'(fail_o[i]), 32'd0);
      end
      hold_code('0, 6);
      pulse_start(1, 1);
      tick();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("t6_to_code_%0d", i), 32'(fail_code_o[i]), 32'd1);
         check_eq($sformatf("t6_to_elapsed_%0d", i), 32'(elapsed_o[i]), 32'd0);
      end

      // randomized runs against the model
      for (int r = 0; r < 40; r++) begin
         int n_wr, steps, dur;
         pulse_abort();
         n_wr = $urandom_range(0, 8);
         for (int w = 0; w < n_wr; w++) write_tab($urandom_range(0, DEPTH-1), alph[$urandom_range(0, 3)]);
         pulse_start($urandom_range(0, DEPTH), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 60));
         steps = $urandom_range(8, 25);
         for (int s = 0; s < steps; s++) begin
            check_bits = ($urandom_range(0, 7) == 0) ? 16'h0000 : alph[$urandom_range(0, 3)];
            dur = $urandom_range(1, 6);
            for (int d = 0; d < dur; d++) begin
               exp_we   = ($urandom_range(0, 9) == 0);
               exp_idx  = IW'($urandom_range(0, DEPTH-1));
               exp_data = alph[$urandom_range(0, 3)];
               start    = ($urandom_range(0, 19) == 0);
               seq_len  = (IW+1)'($urandom_range(0, DEPTH));
               timeout_lim = TIMEOUT_W'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 60));
               abort    = ($urandom_range(0, 39) == 0);
               tick();
               exp_we = 1'b0; start = 1'b0; abort = 1'b0;
            end
         end
         if ($urandom_range(0, 9) == 0) async_reset_now();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
